line_reuse_buffer: RTL and testbench
====================================

Name: line_reuse_buffer

Overview:
- Parametrised successor of the two-lane CCM row-reuse block.
- Stores each row of convolution-window input pixels for LANES channels in a circular register array. While the next row streams in, it replays the stored row so the PE array can reuse vertical neighbours without refetching.
- Adds the following over the previous generation:
  - generic lane count, width and depth;
  - a valid handshake and an explicit state machine;
  - frame and row termination;
  - configuration checking.

Parameters:
- DATA_W, 8: bits per pixel per lane.
- LANES, 2: independent channels sharing one pointer set.
- MAX_L, 512: storage depth in pixels per lane, i.e. the maximum reuse row length.
- COL_W, 10: width of the col_cfg, row_cfg and index ports.
- K, 3: kernel size. Reuse row length is L = col_cfg - (K-1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  frame enable; deassertion aborts the frame.
- col_cfg  in  COL_W  input feature-map columns; sampled on the IDLE->FILL transition.
- row_cfg  in  COL_W  reuse rows per frame; sampled with col_cfg.
- in_valid  in  1  input beat valid.
- in_data  in  LANES*DATA_W  lane-packed pixels; lane 0 in the LSBs.
- out_valid  out  1  out_data holds the previous-row pixel.
- out_data  out  LANES*DATA_W  stored pixels, same packing as in_data.
- out_col  out  COL_W  column index of out_data.
- row_done  out  1  one-cycle pulse on the last beat of each row.
- frame_done  out  1  one-cycle pulse on the last beat of the frame.
- cfg_err  out  1  sticky illegal-configuration flag.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; wr_ptr=0; row_cnt=0.
  - out_valid=0, out_data=0, out_col=0, row_done=0, frame_done=0, cfg_err=0.
  - Array contents are not cleared.
- IDLE, when en=1:
  - Latch L = col_cfg-(K-1) and R = row_cfg.
  - Legal configuration is 2 <= L <= MAX_L and R >= 2. If legal, go to FILL.
  - Otherwise set cfg_err, stay in IDLE, and accept no beats. cfg_err clears only on rst or when en falls.
- FILL (row 0):
  - Each beat with in_valid=1 writes in_data to address wr_ptr.
  - out_valid stays 0.
- RUN (rows 1..R-1), per accepted beat at address wr_ptr:
  - Read the old content, then write the new one (read-before-write).
  - On the next cycle, out_data = the old content, out_col = wr_ptr, out_valid = 1. Latency is 1 cycle.
  - out_valid is 0 in every cycle following a non-accepted beat. There is no back-pressure.
- Pointer wrap:
  - wr_ptr increments 0..L-1.
  - At L-1 with in_valid, wr_ptr returns to 0, row_cnt increments, and row_done pulses in that same cycle.
  - FILL moves to RUN on the first wrap.
- Frame end:
  - When the last beat of row R-1 is accepted, frame_done pulses in that cycle and the state becomes DONE.
  - The output of that last beat still appears one cycle later.
- DONE:
  - Ignores in_valid; out_valid=0 after the final output.
  - Stays in DONE until en falls, then returns to IDLE.
- Abort: en=0 in any state means next state IDLE, counters cleared, pulses 0, no write that cycle, out_valid=0 next cycle.
- Simultaneous in_valid and en fall: en has priority; the beat is dropped.
- rst has priority over everything.
- Arithmetic: L is computed in COL_W+1 bits so an underflow from col_cfg < K-1 flags cfg_err instead of wrapping. All pointers are COL_W bits.
- All lanes share wr_ptr. Lane n uses bits n*DATA_W +: DATA_W.

Optional Feature:
- Macro: REUSE_SERPENTINE_EN.
- Defined (snake traversal):
  - Even rows write ascending 0..L-1; odd rows write descending L-1..0.
  - The wrap for an odd row occurs at address 0; the direction flips at each wrap and wr_ptr holds its end value for the first beat of the next row.
  - out_col reports the actual address, so each output is the vertically adjacent pixel.
  - A pause of zero cycles between rows is allowed.
- Not defined: raster order only, as described above. In this case the direction logic is absent.

Test Plan:
- Basic row replay: K=3, col_cfg=6 (L=4), row_cfg=3, lane0 pixels 1..12 streamed back-to-back. Required response:
  - out_valid is first high at cycle 6 with out_data lane0 = 1, then 2, 3, 4, 5, 6, 7, 8 on successive cycles.
  - row_done pulses on beats 4, 8 and 12.
  - frame_done pulses on beat 12; DONE is entered.
- Gapped input with two lanes: L=4, beats with in_valid toggling 1,0,1,0, lanes 0/1 = {0x10,0x20}, {0x11,0x21}, and so on.
  - out_valid is high only in the cycle after each accepted beat.
  - Lane packing is preserved; out_col = 0..3.
- Configuration errors: col_cfg=2 (L=0) → cfg_err=1 and state stays IDLE; col_cfg=MAX_L+3 → cfg_err=1.
  - Toggling en low clears the flag, then a legal configuration starts normally.
- Mid-row abort: en drops on beat 6 of L=4, R=3.
  - No write occurs on that beat; out_valid=0 on the next cycle; state is IDLE.
  - Re-enabling starts again in FILL with wr_ptr=0.
- Reset mid-frame: rst=1 during RUN.
  - All outputs are 0 on the following cycle.
  - After rst falls and en is held at 1, the block re-enters FILL.
- REUSE_SERPENTINE_EN, L=4, pixels 1..12:
  - Row 1 outputs 4, 3, 2, 1 with out_col = 3, 2, 1, 0.
  - Row 2 outputs 8, 7, 6, 5 with out_col = 0, 1, 2, 3.

Source files
------------

// File: rtl/line_reuse_buffer.sv
// line_reuse_buffer
//
// Keeps one row of convolution-window pixels for LANES channels in a circular
// register array. While the next row streams in, every accepted beat reads the
// stored pixel at the write address before overwriting it. The old pixel is
// presented one cycle later, so the PE array receives the vertical neighbour
// without refetching it.
//
// Row 0 only fills the array (FILL). Rows 1..R-1 replay the array (RUN).
// After the last beat of the frame the block waits in DONE until en_i falls.
// Reuse row length is L = col_cfg_i - (K-1). A configuration is legal when
// 2 <= L <= MAX_L and R >= 2.
//
// Optional feature: define REUSE_SERPENTINE_EN for snake traversal. Even rows
// write ascending addresses and odd rows write descending addresses. Without
// the macro the block uses raster order only.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   en_i         frame enable; low aborts the frame and clears cfg_err_o
//   col_cfg_i    feature-map columns, sampled in IDLE
//   row_cfg_i    reuse rows per frame, sampled with col_cfg_i
//   in_valid_i   input beat valid
//   in_data_i    lane-packed pixels, lane 0 in the LSBs
//   out_valid_o  out_data_o/out_col_o carry a previous-row pixel
//   out_data_o   stored pixels, same packing as in_data_i
//   out_col_o    array address of out_data_o
//   row_done_o   pulse on the last beat of each row
//   frame_done_o pulse on the last beat of the frame
//   cfg_err_o    sticky illegal-configuration flag
module line_reuse_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 2,
  parameter int unsigned MAX_L  = 512,
  parameter int unsigned COL_W  = 10,
  parameter int unsigned K      = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [COL_W-1:0]        col_cfg_i,
  input  logic [COL_W-1:0]        row_cfg_i,
  input  logic                    in_valid_i,
  input  logic [LANES*DATA_W-1:0] in_data_i,
  output logic                    out_valid_o,
  output logic [LANES*DATA_W-1:0] out_data_o,
  output logic [COL_W-1:0]        out_col_o,
  output logic                    row_done_o,
  output logic                    frame_done_o,
  output logic                    cfg_err_o
);

  localparam int unsigned DW = LANES * DATA_W;
  localparam int unsigned AW = (MAX_L > 1) ? $clog2(MAX_L) : 1;

  typedef enum logic [1:0] {StIdle, StFill, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [COL_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [COL_W-1:0] row_cnt_q, row_cnt_d;
  logic [COL_W-1:0] len_q, len_d;
  logic [COL_W-1:0] rows_q, rows_d;
  logic             cfg_err_q, cfg_err_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
`ifdef REUSE_SERPENTINE_EN
  logic             dir_q, dir_d;  // 1: descending addresses
`endif

  logic [DW-1:0]    mem_q [MAX_L];
  logic [AW-1:0]    addr;
  logic             accept, at_end, row_pulse, frame_pulse;

  // One extra bit so that col_cfg_i < K-1 gives a huge value, not a small one.
  logic [COL_W:0]   len_calc;
  logic             cfg_ok;

  assign len_calc = {1'b0, col_cfg_i} - (COL_W + 1)'(K - 1);
  assign cfg_ok   = (len_calc >= (COL_W + 1)'(2)) && (len_calc <= (COL_W + 1)'(MAX_L)) &&
                    (row_cfg_i >= COL_W'(2));
  assign addr     = wr_ptr_q[AW-1:0];

`ifdef REUSE_SERPENTINE_EN
  assign at_end = dir_q ? (wr_ptr_q == '0) : (wr_ptr_q == len_q - COL_W'(1));
`else
  assign at_end = (wr_ptr_q == len_q - COL_W'(1));
`endif

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    row_cnt_d   = row_cnt_q;
    len_d       = len_q;
    rows_d      = rows_q;
    cfg_err_d   = cfg_err_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_col_d   = out_col_q;
    accept      = 1'b0;
    row_pulse   = 1'b0;
    frame_pulse = 1'b0;
`ifdef REUSE_SERPENTINE_EN
    dir_d       = dir_q;
`endif

    if (!en_i) begin
      // Abort: en_i wins over a simultaneous beat, which is dropped.
      state_d   = StIdle;
      wr_ptr_d  = '0;
      row_cnt_d = '0;
      cfg_err_d = 1'b0;
`ifdef REUSE_SERPENTINE_EN
      dir_d     = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          // A flagged configuration stays blocked until en_i falls.
          if (!cfg_err_q) begin
            len_d  = len_calc[COL_W-1:0];
            rows_d = row_cfg_i;
            if (cfg_ok) begin
              state_d = StFill;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        StFill, StRun: begin
          if (in_valid_i) begin
            accept = 1'b1;
            if (state_q == StRun) begin
              // Read-before-write: mem_q still holds the previous row here.
              out_valid_d = 1'b1;
              out_data_d  = mem_q[addr];
              out_col_d   = wr_ptr_q;
            end
            if (at_end) begin
              row_pulse = 1'b1;
              row_cnt_d = row_cnt_q + COL_W'(1);
`ifdef REUSE_SERPENTINE_EN
              // Pointer holds its end value; the next row walks back.
              dir_d     = ~dir_q;
`else
              wr_ptr_d  = '0;
`endif
              if (state_q == StFill) begin
                state_d = StRun;
              end else if (row_cnt_q == rows_q - COL_W'(1)) begin
                frame_pulse = 1'b1;
                state_d     = StDone;
              end
            end else begin
`ifdef REUSE_SERPENTINE_EN
              wr_ptr_d = dir_q ? wr_ptr_q - COL_W'(1) : wr_ptr_q + COL_W'(1);
`else
              wr_ptr_d = wr_ptr_q + COL_W'(1);
`endif
            end
          end
        end
        StDone: begin
          // Beats are ignored until en_i falls.
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      row_cnt_q   <= '0;
      len_q       <= '0;
      rows_q      <= '0;
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_col_q   <= '0;
`ifdef REUSE_SERPENTINE_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      row_cnt_q   <= row_cnt_d;
      len_q       <= len_d;
      rows_q      <= rows_d;
      cfg_err_q   <= cfg_err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_col_q   <= out_col_d;
`ifdef REUSE_SERPENTINE_EN
      dir_q       <= dir_d;
`endif
    end
  end

  // The storage array is not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (accept && !rst_i) begin
      mem_q[addr] <= in_data_i;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_col_o    = out_col_q;
  assign cfg_err_o    = cfg_err_q;
  assign row_done_o   = row_pulse & ~rst_i;
  assign frame_done_o = frame_pulse & ~rst_i;

endmodule

// File: tb/tb_line_reuse_buffer.sv
module tb_line_reuse_buffer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LANES  = 2;
  localparam int unsigned MAX_L  = 512;
  localparam int unsigned COL_W  = 10;
  localparam int unsigned K      = 3;

  logic                    clk = 1'b0;
  logic                    rst, en, in_valid;
  logic [COL_W-1:0]        col_cfg, row_cfg;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    out_valid, row_done, frame_done, cfg_err;
  logic [LANES*DATA_W-1:0] out_data;
  logic [COL_W-1:0]        out_col;

  line_reuse_buffer #(
    .DATA_W(DATA_W), .LANES(LANES), .MAX_L(MAX_L), .COL_W(COL_W), .K(K)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .col_cfg_i   (col_cfg),
    .row_cfg_i   (row_cfg),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_col_o   (out_col),
    .row_done_o  (row_done),
    .frame_done_o(frame_done),
    .cfg_err_o   (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               en;
    bit               iv;
    logic [7:0]       d0;
    logic [7:0]       d1;
    bit               rd;
    bit               fd;
    bit               ov;
    logic [7:0]       e0;
    logic [7:0]       e1;
    logic [COL_W-1:0] ec;
  } vec_t;

  typedef struct {
    logic [7:0]       e0;
    logic [7:0]       e1;
    logic [COL_W-1:0] ec;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Index within a row of the pixel that lands at position j of that row.
  function automatic int addr_of(input int row, input int j, input int len);
`ifdef REUSE_SERPENTINE_EN
    return (row % 2 == 1) ? len - 1 - j : j;
`else
    return j;
`endif
  endfunction

  function automatic vec_t idle_vec(input bit e);
    vec_t v;
    v = '{en: e, iv: 1'b0, d0: 8'hEE, d1: 8'hEE, rd: 1'b0, fd: 1'b0, ov: 1'b0,
          e0: 8'h0, e1: 8'h0, ec: '0};
    return v;
  endfunction

  // Streams nbeats consecutive pixels (b0+i, b1+i) for an L x R frame.
  // Beats past the frame end are presented while the block is in DONE.
  task automatic add_frame(input int len, input int rows, input int nbeats,
                           input int b0, input int b1, input bit gap);
    vec_t v;
    vecs.push_back(idle_vec(1'b1));
    for (int b = 0; b < nbeats; b++) begin
      int row, j, a, p;
      row  = b / len;
      j    = b % len;
      a    = addr_of(row, j, len);
      v    = idle_vec(1'b1);
      v.iv = 1'b1;
      v.d0 = 8'(b0 + b);
      v.d1 = 8'(b1 + b);
      v.rd = (row < rows) && (j == len - 1);
      v.fd = (row == rows - 1) && (j == len - 1);
      v.ov = (row >= 1) && (row < rows);
      if (v.ov) begin
        p    = (row - 1) * len + addr_of(row - 1, a, len);
        v.e0 = 8'(b0 + p);
        v.e1 = 8'(b1 + p);
        v.ec = COL_W'(a);
      end
      vecs.push_back(v);
      if (gap) vecs.push_back(idle_vec(1'b1));
    end
  endtask

  task automatic apply(input vec_t v, input int n);
    exp_t e;
    rst      = 1'b0;
    en       = v.en;
    in_valid = v.iv;
    in_data  = {v.d1, v.d0};
    if (v.ov) sb.push_back('{e0: v.e0, e1: v.e1, ec: v.ec});
    @(negedge clk);
    chk($sformatf("row_done v%0d", n), 32'(row_done), 32'(v.rd));
    chk($sformatf("frame_done v%0d", n), 32'(frame_done), 32'(v.fd));
    tick();
    chk($sformatf("out_valid v%0d", n), 32'(out_valid), 32'(v.ov));
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output v%0d: got %0h required none", n, out_data);
      end else begin
        e = sb.pop_front();
        chk($sformatf("lane0 v%0d", n), 32'(out_data[7:0]), 32'(e.e0));
        chk($sformatf("lane1 v%0d", n), 32'(out_data[15:8]), 32'(e.e1));
        chk($sformatf("out_col v%0d", n), 32'(out_col), 32'(e.ec));
      end
    end
  endtask

  task automatic run_table();
    int n = 0;
    while (vecs.size() > 0) begin
      apply(vecs.pop_front(), n);
      n++;
    end
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Illegal configuration must flag, block beats, and clear when en falls.
  task automatic cfg_case(input int col, input int rows, input string name);
    col_cfg  = COL_W'(col);
    row_cfg  = COL_W'(rows);
    en       = 1'b1;
    in_valid = 1'b0;
    tick();
    chk({name, "_cfg_err"}, 32'(cfg_err), 32'd1);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i + 1);
      @(negedge clk);
      chk({name, "_row_done"}, 32'(row_done), 32'd0);
      tick();
      chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
    end
    chk({name, "_sticky"}, 32'(cfg_err), 32'd1);
    en       = 1'b0;
    in_valid = 1'b0;
    tick();
    chk({name, "_cleared"}, 32'(cfg_err), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    col_cfg  = COL_W'(6);
    row_cfg  = COL_W'(3);
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_col", 32'(out_col), 32'd0);
    chk("rst_row_done", 32'(row_done), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst = 1'b0;
    tick();

    // Basic replay, lane0 = 1..12, plus one beat ignored in DONE.
    add_frame(4, 3, 13, 1, 8'h80, 1'b0);
    vecs.push_back(idle_vec(1'b0));
    run_table();

    // Gapped input, two lanes.
    add_frame(4, 3, 8, 8'h10, 8'h20, 1'b1);
    vecs.push_back(idle_vec(1'b0));
    run_table();

    // Smallest legal frame: L=2, R=2.
    col_cfg = COL_W'(4);
    row_cfg = COL_W'(2);
    add_frame(2, 2, 5, 8'h30, 8'h38, 1'b0);
    vecs.push_back(idle_vec(1'b0));
    run_table();

    // Configuration errors, then the boundary L = MAX_L is legal.
    cfg_case(2, 3, "len_zero");
    cfg_case(MAX_L + 3, 3, "len_over");
    cfg_case(1, 3, "len_underflow");
    cfg_case(6, 1, "rows_one");
    col_cfg = COL_W'(MAX_L + 2);
    row_cfg = COL_W'(3);
    en      = 1'b1;
    tick();
    tick();
    chk("len_max_cfg_err", 32'(cfg_err), 32'd0);
    en = 1'b0;
    tick();

    // Mid-row abort on beat 6, then a clean restart.
    col_cfg = COL_W'(6);
    row_cfg = COL_W'(3);
    add_frame(4, 3, 5, 8'h40, 8'h50, 1'b0);
    begin
      vec_t v;
      v    = idle_vec(1'b0);
      v.iv = 1'b1;
      v.d0 = 8'h99;
      vecs.push_back(v);
    end
    add_frame(4, 3, 12, 8'h60, 8'h70, 1'b0);
    vecs.push_back(idle_vec(1'b0));
    run_table();

    // Reset during RUN with en held high.
    add_frame(4, 3, 6, 8'h80, 8'h90, 1'b0);
    run_table();
    rst      = 1'b1;
    en       = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hABCD;
    @(negedge clk);
    chk("mid_rst_row_done", 32'(row_done), 32'd0);
    chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
    tick();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_out_col", 32'(out_col), 32'd0);
    chk("mid_rst_cfg_err", 32'(cfg_err), 32'd0);
    add_frame(4, 3, 12, 8'hA0, 8'hB0, 1'b0);
    vecs.push_back(idle_vec(1'b0));
    run_table();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
